multiplier: RTL



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/multiplier.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared M-extension unit definitions: data width, multiply opcodes, multiplier FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

    localparam int XLEN = 32;

    // Encoding follows funct3[1:0] of the RISC-V multiply instructions.
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mul_state_e;

endpackage

// File: rtl/multiplier.sv
// Multi-cycle 32x32 radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Latency: 33 cycles from the accept edge (1 cycle when an operand is 0 or |mplier| is 1).
// Backpressure: start (en) is accepted only while done=1; en while busy is ignored.
//
// Ports:
//   clk      - clock, all state on the rising edge
//   clr      - synchronous active-high reset, highest priority
//   en       - start request, sampled only while done=1
//   mcand    - multiplicand (rs1), mplier - multiplier (rs2)
//   op       - opcode (funct3[1:0]): MUL, MULH, MULHSU, MULHU
//   result   - low word for MUL, high word otherwise; product - full 64-bit product
//   done     - idle and result valid; busy - inverse of done
module multiplier
    import mdu_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic [XLEN-1:0]     mcand,
    input  logic [XLEN-1:0]     mplier,
    input  logic [1:0]          op,
    output logic [XLEN-1:0]     result,
    output logic [2*XLEN-1:0]   product,
    output logic                done,
    output logic                busy
);

    mul_state_e             state_q,   state_d;
    mul_op_e                op_q,      op_d;
    logic                   neg_q,     neg_d;
    logic [2*XLEN-1:0]      mcand_q,   mcand_d;
    logic [XLEN-1:0]        mplier_q,  mplier_d;
    logic [2*XLEN-1:0]      acc_q,     acc_d;
    logic [4:0]             cnt_q,     cnt_d;
    logic [XLEN-1:0]        result_q,  result_d;
    logic [2*XLEN-1:0]      product_q, product_d;

    mul_op_e                op_in;
    logic                   sign_a;
    logic                   sign_b;
    logic [XLEN-1:0]        mag_a;
    logic [XLEN-1:0]        mag_b;
    logic [2*XLEN-1:0]      fixed_prod;

    // Signs only count when the opcode treats that operand as signed.
    // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
    always_comb begin
        op_in  = mul_op_e'(op);
        sign_a = (op_in != MULHU) & mcand[XLEN-1];
        sign_b = ((op_in == MUL) || (op_in == MULH)) & mplier[XLEN-1];
        mag_a  = sign_a ? -mcand  : mcand;
        mag_b  = sign_b ? -mplier : mplier;
    end

    assign fixed_prod = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    op_d     = op_in;
                    neg_d    = sign_a ^ sign_b;
                    mcand_d  = {{XLEN{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if ((mag_a == '0) || (mag_b == '0)) begin
                        state_d = FIX;
                    end else if (mag_b == XLEN'(1)) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            // The multiplicand walks left and the multiplier walks right, so
            // iteration cnt sees |mcand| << cnt against |mplier| bit[cnt]
            // without a 64-bit barrel shifter.
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                product_d = fixed_prod;
                result_d  = (op_q == MUL) ? fixed_prod[XLEN-1:0]
                                          : fixed_prod[2*XLEN-1:XLEN];
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            product_q <= product_d;
        end
    end

    assign result  = result_q;
    assign product = product_q;
    assign done    = (state_q == IDLE);
    assign busy    = (state_q != IDLE);

endmodule
